adder_arbiter: RTL and testbench

- Shares one CLA16_higher 16-bit add/subtract datapath between N_REQ independent requesters.
- Each requester presents operands, subtract and sign flags over a valid/ready handshake.
- A round-robin arbiter grants one request, and the block sequences the datapath through a small FSM.
- The registered result and overflow are returned on a single response channel, tagged with the requester id.

---
 rtl/adder_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_adder_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : adder_arbiter
// Description : Shares one 16-bit add/subtract datapath between N_REQ
//               requesters. A round-robin arbiter grants one request in IDLE.
//               The operation runs in EXEC, and the registered result is
//               presented in RESP, tagged with the id of the requester.
// Ports       : clk, rst (async, active high)
//               req_valid/req_ready  per-requester handshake (ready one-hot)
//               req_a/req_b          16-bit operands packed per requester
//               req_sub/req_sign     subtract select / signed overflow rule
//               rsp_valid/rsp_ready  response handshake
//               rsp_id/rsp_res/rsp_ovf  response payload
//               ovf_count            saturating overflow-response count
//                                    (only with ADDER_ARBITER_OVF_COUNT_EN)
// Options     : `define ADDER_ARBITER_OVF_COUNT_EN adds ovf_count.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [16*N_REQ-1:0]  req_a,
    input  logic [16*N_REQ-1:0]  req_b,
    input  logic [N_REQ-1:0]     req_sub,
    input  logic [N_REQ-1:0]     req_sign,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [15:0]          rsp_res,
    output logic                 rsp_ovf
`ifdef ADDER_ARBITER_OVF_COUNT_EN
    ,
    output logic [15:0]          ovf_count
`endif
);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_exec = 2'd1;
    localparam logic [1:0] c_resp = 2'd2;

    // Valid vector padded to a power of two so the ID_W-bit scan index is
    // always in range, whatever N_REQ is.
    localparam int c_npad = 1 << ID_W;

    logic [1:0]      r_state;
    logic [ID_W-1:0] r_last;
    logic [15:0]     r_a;
    logic [15:0]     r_b;
    logic            r_sub;
    logic            r_sign;
    logic [ID_W-1:0] r_id;

    logic [c_npad-1:0] w_valid_pad;
    logic [ID_W:0]     w_scan;
    logic [ID_W-1:0]   w_idx;
    logic              w_any;
    logic [ID_W-1:0]   w_gnt_id;
    logic [15:0]       w_a;
    logic [15:0]       w_b;
    logic              w_sub;
    logic              w_sign;

    // Round-robin scan starting one past the last grant, wrapping at N_REQ.
    always_comb begin
        w_valid_pad = c_npad'(req_valid);
        w_scan      = '0;
        w_idx       = '0;
        w_any       = 1'b0;
        w_gnt_id    = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_scan = {1'b0, r_last} + (ID_W+1)'(k);
            if (w_scan >= (ID_W+1)'(N_REQ)) begin
                w_scan = w_scan - (ID_W+1)'(N_REQ);
            end
            w_idx = w_scan[ID_W-1:0];
            if (!w_any && w_valid_pad[w_idx]) begin
                w_any    = 1'b1;
                w_gnt_id = w_idx;
            end
        end
    end

    // Operand select for the granted requester.
    always_comb begin
        w_a    = '0;
        w_b    = '0;
        w_sub  = 1'b0;
        w_sign = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_gnt_id == ID_W'(i)) begin
                w_a    = req_a[16*i +: 16];
                w_b    = req_b[16*i +: 16];
                w_sub  = req_sub[i];
                w_sign = req_sign[i];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (r_state == c_idle && w_any) begin
            req_ready = N_REQ'(1) << w_gnt_id;
        end
    end

    // Shared datapath, fed only from the latched operands.
    logic [15:0] w_bop;
    logic [16:0] w_sum;
    logic [15:0] w_res;
    logic        w_ovf;

    always_comb begin
        w_bop = r_sub ? ~r_b : r_b;
        w_sum = {1'b0, r_a} + {1'b0, w_bop} + {16'b0, r_sub};
        w_res = w_sum[15:0];
        // Unsigned: carry out for add, borrow (inverted carry) for subtract.
        // Signed: same-sign effective operands producing a different sign.
        if (r_sign) begin
            w_ovf = (r_a[15] == w_bop[15]) && (w_res[15] != r_a[15]);
        end else begin
            w_ovf = w_sum[16] ^ r_sub;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_idle;
            r_last    <= ID_W'(N_REQ-1);
            r_a       <= '0;
            r_b       <= '0;
            r_sub     <= 1'b0;
            r_sign    <= 1'b0;
            r_id      <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_res   <= '0;
            rsp_ovf   <= 1'b0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (w_any) begin
                        r_a     <= w_a;
                        r_b     <= w_b;
                        r_sub   <= w_sub;
                        r_sign  <= w_sign;
                        r_id    <= w_gnt_id;
                        r_last  <= w_gnt_id;
                        r_state <= c_exec;
                    end
                end
                c_exec: begin
                    rsp_res   <= w_res;
                    rsp_ovf   <= w_ovf;
                    rsp_id    <= r_id;
                    rsp_valid <= 1'b1;
                    r_state   <= c_resp;
                end
                c_resp: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_state   <= c_idle;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    r_state   <= c_idle;
                end
            endcase
        end
    end

`ifdef ADDER_ARBITER_OVF_COUNT_EN
    logic [15:0] r_ovf_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf_count <= '0;
        end else if (r_state == c_resp && rsp_valid && rsp_ready && rsp_ovf
                     && r_ovf_count != 16'hFFFF) begin
            r_ovf_count <= r_ovf_count + 16'd1;
        end
    end

    assign ovf_count = r_ovf_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_adder_arbiter
// Description : Directed self-checking bench for adder_arbiter (N_REQ=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_arbiter;

    localparam int N_REQ = 4;
    localparam int ID_W  = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ-1:0]   req_ready;
    logic [16*N_REQ-1:0] req_a;
    logic [16*N_REQ-1:0] req_b;
    logic [N_REQ-1:0]   req_sub;
    logic [N_REQ-1:0]   req_sign;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [ID_W-1:0]    rsp_id;
    logic [15:0]        rsp_res;
    logic               rsp_ovf;
`ifdef ADDER_ARBITER_OVF_COUNT_EN
    logic [15:0]        ovf_count;
`endif

    int n_vec = 0;
    int n_err = 0;

    adder_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sub   (req_sub),
        .req_sign  (req_sign),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_res   (rsp_res),
        .rsp_ovf   (rsp_ovf)
`ifdef ADDER_ARBITER_OVF_COUNT_EN
        ,
        .ovf_count (ovf_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b,
                           input logic s, input logic sg);
        req_a[16*i +: 16] = a;
        req_b[16*i +: 16] = b;
        req_sub[i]        = s;
        req_sign[i]       = sg;
    endtask

    // Drives one request from IDLE (called at posedge+1, rsp_ready=1) and
    // returns what was observed; the calling test does the comparisons.
    task automatic run_op(input int i, input logic [15:0] a, input logic [15:0] b,
                          input logic s, input logic sg,
                          output logic [3:0] gnt, output int lat,
                          output logic [15:0] res, output logic ovf,
                          output logic [1:0] id);
        set_req(i, a, b, s, sg);
        req_valid[i] = 1'b1;
        #1;
        gnt = req_ready;
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        res = rsp_res;
        ovf = rsp_ovf;
        id  = rsp_id;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_sub   = '0;
        req_sign  = '0;
        rsp_ready = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        n_vec++;
        if ({req_ready, rsp_valid, rsp_id, rsp_res, rsp_ovf} !== 24'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b id=%0d res=%h ovf=%b, want all 0",
                     req_ready, rsp_valid, rsp_id, rsp_res, rsp_ovf);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if (req_ready !== 4'b0000 || rsp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL idle_no_req: got rdy=%b vld=%b, want 0000 0", req_ready, rsp_valid);
        end
    endtask

    task automatic test_fairness();
        logic [15:0] exp_res [4] = '{16'h1001, 16'h4DCC, 16'h0000, 16'hFFFF};
        logic        exp_ovf [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [3:0]  exp_rdy;
        int ph;
        int g;
        rst = 1'b1;
        #1;
        rst = 1'b0;
        set_req(0, 16'h1000, 16'h0001, 1'b0, 1'b0);
        set_req(1, 16'h5000, 16'h0234, 1'b1, 1'b0);
        set_req(2, 16'h8000, 16'h8000, 1'b0, 1'b1);
        set_req(3, 16'h0001, 16'h0002, 1'b1, 1'b1);
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        #1;
        for (int c = 0; c < 15; c++) begin
            ph = c % 3;
            g  = (c / 3) % 4;
            exp_rdy = (ph == 0) ? (4'b0001 << g) : 4'b0000;
            n_vec++;
            if (req_ready !== exp_rdy) begin
                n_err++;
                $display("FAIL fair_ready c=%0d: got %b, want %b", c, req_ready, exp_rdy);
            end
            if (ph == 2) begin
                n_vec++;
                if (rsp_valid !== 1'b1 || rsp_id !== 2'(g) || rsp_res !== exp_res[g]
                    || rsp_ovf !== exp_ovf[g]) begin
                    n_err++;
                    $display("FAIL fair_rsp c=%0d: got vld=%b id=%0d res=%h ovf=%b, want 1 %0d %h %b",
                             c, rsp_valid, rsp_id, rsp_res, rsp_ovf, g, exp_res[g], exp_ovf[g]);
                end
            end else begin
                n_vec++;
                if (rsp_valid !== 1'b0) begin
                    n_err++;
                    $display("FAIL fair_novalid c=%0d: got vld=%b, want 0", c, rsp_valid);
                end
            end
            @(posedge clk); #1;
        end
        req_valid = '0;
    endtask

    task automatic test_single();
        logic [3:0]  gnt;
        int          lat;
        logic [15:0] res;
        logic        ovf;
        logic [1:0]  id;
        run_op(0, 16'h0123, 16'h0345, 1'b0, 1'b0, gnt, lat, res, ovf, id);
        n_vec++;
        if (gnt !== 4'b0001 || lat != 2 || res !== 16'h0468 || ovf !== 1'b0 || id !== 2'd0) begin
            n_err++;
            $display("FAIL single_req0: got gnt=%b lat=%0d res=%h ovf=%b id=%0d, want 0001 2 0468 0 0",
                     gnt, lat, res, ovf, id);
        end
        n_vec++;
        if (rsp_valid !== 1'b0 || rsp_res !== 16'h0468) begin
            n_err++;
            $display("FAIL single_after: got vld=%b res=%h, want 0 0468", rsp_valid, rsp_res);
        end
    endtask

    task automatic test_two_requesters();
        logic [3:0]  gnt;
        int          lat;
        logic [15:0] res;
        logic        ovf;
        logic [1:0]  id;
        run_op(2, 16'h7123, 16'h7345, 1'b0, 1'b1, gnt, lat, res, ovf, id);
        n_vec++;
        if (gnt !== 4'b0100 || lat != 2 || res !== 16'hE468 || ovf !== 1'b1 || id !== 2'd2) begin
            n_err++;
            $display("FAIL req2_signed_add: got gnt=%b lat=%0d res=%h ovf=%b id=%0d, want 0100 2 E468 1 2",
                     gnt, lat, res, ovf, id);
        end
        run_op(1, 16'hF123, 16'h1345, 1'b1, 1'b0, gnt, lat, res, ovf, id);
        n_vec++;
        if (gnt !== 4'b0010 || lat != 2 || res !== 16'hDDDE || ovf !== 1'b0 || id !== 2'd1) begin
            n_err++;
            $display("FAIL req1_unsigned_sub: got gnt=%b lat=%0d res=%h ovf=%b id=%0d, want 0010 2 DDDE 0 1",
                     gnt, lat, res, ovf, id);
        end
    endtask

    task automatic test_boundary();
        logic [15:0] va [4] = '{16'hFFFF, 16'h0000, 16'h8000, 16'h7FFF};
        logic [15:0] vb [4] = '{16'h0001, 16'h0001, 16'h0001, 16'h0001};
        logic        vs [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic        vg [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [15:0] er [4] = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000};
        logic        eo [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
        logic [3:0]  gnt;
        int          lat;
        logic [15:0] res;
        logic        ovf;
        logic [1:0]  id;
        for (int t = 0; t < 4; t++) begin
            run_op(3, va[t], vb[t], vs[t], vg[t], gnt, lat, res, ovf, id);
            n_vec++;
            if (gnt !== 4'b1000 || res !== er[t] || ovf !== eo[t] || id !== 2'd3) begin
                n_err++;
                $display("FAIL boundary_%0d: got gnt=%b res=%h ovf=%b id=%0d, want 1000 %h %b 3",
                         t, gnt, res, ovf, id, er[t], eo[t]);
            end
        end
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        set_req(3, 16'hA123, 16'hA345, 1'b0, 1'b1);
        req_valid[3] = 1'b1;
        #1;
        n_vec++;
        if (req_ready !== 4'b1000) begin
            n_err++;
            $display("FAIL bp_grant: got %b, want 1000", req_ready);
        end
        @(posedge clk); #1;
        req_valid[3] = 1'b0;
        set_req(1, 16'h0002, 16'h0003, 1'b0, 1'b0);
        req_valid[1] = 1'b1;
        #1;
        n_vec++;
        if (req_ready !== 4'b0000 || rsp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_exec: got rdy=%b vld=%b, want 0000 0", req_ready, rsp_valid);
        end
        @(posedge clk); #1;
        for (int c = 0; c < 5; c++) begin
            n_vec++;
            if (rsp_valid !== 1'b1 || rsp_res !== 16'h4468 || rsp_ovf !== 1'b1
                || rsp_id !== 2'd3 || req_ready !== 4'b0000) begin
                n_err++;
                $display("FAIL bp_hold c=%0d: got vld=%b res=%h ovf=%b id=%0d rdy=%b, want 1 4468 1 3 0000",
                         c, rsp_valid, rsp_res, rsp_ovf, rsp_id, req_ready);
            end
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if (rsp_valid !== 1'b0 || rsp_res !== 16'h4468 || rsp_ovf !== 1'b1
            || req_ready !== 4'b0010) begin
            n_err++;
            $display("FAIL bp_release: got vld=%b res=%h ovf=%b rdy=%b, want 0 4468 1 0010",
                     rsp_valid, rsp_res, rsp_ovf, req_ready);
        end
        // Requester 1 withdraws before its grant edge: nothing must happen.
        req_valid[1] = 1'b0;
        #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_vec++;
        if (rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin
            n_err++;
            $display("FAIL withdraw: got vld=%b rdy=%b, want 0 0000", rsp_valid, req_ready);
        end
    endtask

    task automatic test_reset_exec();
        set_req(2, 16'h1111, 16'h1111, 1'b0, 1'b0);
        req_valid[2] = 1'b1;
        @(posedge clk); #1;
        req_valid[2] = 1'b0;
        rst = 1'b1;
        #1;
        n_vec++;
        if ({req_ready, rsp_valid, rsp_id, rsp_res, rsp_ovf} !== 24'h0) begin
            n_err++;
            $display("FAIL rst_exec_outputs: got rdy=%b vld=%b id=%0d res=%h ovf=%b, want all 0",
                     req_ready, rsp_valid, rsp_id, rsp_res, rsp_ovf);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            n_vec++;
            if (rsp_valid !== 1'b0) begin
                n_err++;
                $display("FAIL rst_no_rsp c=%0d: got vld=%b, want 0", c, rsp_valid);
            end
        end
        req_valid = 4'b1111;
        #1;
        n_vec++;
        if (req_ready !== 4'b0001) begin
            n_err++;
            $display("FAIL rst_first_grant: got %b, want 0001", req_ready);
        end
        req_valid = '0;
        #1;
    endtask

`ifdef ADDER_ARBITER_OVF_COUNT_EN
    task automatic test_ovf_count();
        logic [3:0]  gnt;
        int          lat;
        logic [15:0] res;
        logic        ovf;
        logic [1:0]  id;
        rst = 1'b1;
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_op(0, 16'h7123, 16'h7345, 1'b0, 1'b1, gnt, lat, res, ovf, id);
        run_op(0, 16'h0123, 16'h0345, 1'b0, 1'b0, gnt, lat, res, ovf, id);
        run_op(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, gnt, lat, res, ovf, id);
        run_op(0, 16'hF123, 16'h1345, 1'b1, 1'b0, gnt, lat, res, ovf, id);
        run_op(0, 16'h8000, 16'h0001, 1'b1, 1'b1, gnt, lat, res, ovf, id);
        n_vec++;
        if (ovf_count !== 16'd3) begin
            n_err++;
            $display("FAIL ovf_count: got %h, want 0003", ovf_count);
        end
        force dut.r_ovf_count = 16'hFFFF;
        #1;
        release dut.r_ovf_count;
        run_op(0, 16'h7123, 16'h7345, 1'b0, 1'b1, gnt, lat, res, ovf, id);
        n_vec++;
        if (ovf_count !== 16'hFFFF) begin
            n_err++;
            $display("FAIL ovf_count_sat: got %h, want FFFF", ovf_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_fairness();
        test_single();
        test_two_requesters();
        test_boundary();
        test_backpressure();
        test_reset_exec();
`ifdef ADDER_ARBITER_OVF_COUNT_EN
        test_ovf_count();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
